sw_input_unit: RTL

- Input-side counterpart to the seven-segment output path: samples the 10 board switches (SW_i) and delivers clean values to the processor core.
- Synchronises, debounces and change-detects the switch bank, then offers each new stable value over a valid/ack handshake.
- Sits between the board pins and the core's input-instruction datapath; the current debounced level is also exported for direct use.

---
 rtl/sw_input_unit_pkg.sv | 14 +
 rtl/sw_sync_debounce.sv | 64 ++++++
 rtl/sw_input_unit.sv | 96 +++++++++
 3 files changed

// File: rtl/sw_input_unit_pkg.sv
// Shared constants and FSM encoding for the switch input unit.
// Holds the default bank width, short simulation timing values and states.
package sw_input_unit_pkg;

   localparam int SW_WIDTH_DEF       = 10;
   localparam int SIM_TICK_DIV       = 4;
   localparam int SIM_STABLE_TICKS   = 3;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_VALID = 1'b1
   } sw_state_e;

endpackage

// File: rtl/sw_sync_debounce.sv
// Synchroniser, sample prescaler and bank debouncer for the switch inputs.
// Ports: i_clk, i_rst (sync, high), i_sw raw in, o_deb debounced, o_commit pulse.
module sw_sync_debounce
   import sw_input_unit_pkg::*;
#(
   parameter int SW_WIDTH     = SW_WIDTH_DEF,
   parameter int TICK_DIV     = 50000,
   parameter int STABLE_TICKS = 4
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [SW_WIDTH-1:0] i_sw,
   output logic [SW_WIDTH-1:0] o_deb,
   output logic                o_commit
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int CW = $clog2(STABLE_TICKS) + 1;
   localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
   localparam logic [CW-1:0] C_SAT  = CW'(STABLE_TICKS - 1);

   logic [SW_WIDTH-1:0] r_sync1;
   logic [SW_WIDTH-1:0] r_sync2;
   logic [SW_WIDTH-1:0] r_cand;
   logic [SW_WIDTH-1:0] r_deb;
   logic [PW-1:0]       r_presc;
   logic [CW-1:0]       r_cnt;
   logic                r_commit;
   logic                w_tick;

   assign w_tick   = (r_presc == P_LAST);
   assign o_deb    = r_deb;
   assign o_commit = r_commit;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync1  <= '0;
         r_sync2  <= '0;
         r_cand   <= '0;
         r_deb    <= '0;
         r_presc  <= '0;
         r_cnt    <= '0;
         r_commit <= 1'b0;
      end else begin
         r_sync1  <= i_sw;
         r_sync2  <= r_sync1;
         r_presc  <= w_tick ? '0 : r_presc + 1'b1;
         r_commit <= 1'b0;
         if (w_tick) begin
            // Any disagreement restarts the confirmation run.
            if (r_sync2 != r_cand) begin
               r_cand <= r_sync2;
               r_cnt  <= '0;
            end else if (r_cnt < C_SAT) begin
               r_cnt <= r_cnt + 1'b1;
            end else if (r_cand != r_deb) begin
               r_deb    <= r_cand;
               r_commit <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/sw_input_unit.sv
// Switch input unit: debounced switch bank offered to the core by valid/ack.
// Ports: clk_i, rst_i, SW_i, sw_level_o, sw_data_o, sw_valid_o, sw_ack_i, sw_overrun_o.
module sw_input_unit
   import sw_input_unit_pkg::*;
#(
   parameter int SW_WIDTH     = SW_WIDTH_DEF,
   parameter int TICK_DIV     = 50000,
   parameter int STABLE_TICKS = 4
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [SW_WIDTH-1:0] SW_i,
   output logic [SW_WIDTH-1:0] sw_level_o,
   output logic [SW_WIDTH-1:0] sw_data_o,
   output logic                sw_valid_o,
   input  logic                sw_ack_i,
   output logic                sw_overrun_o
);

   logic [SW_WIDTH-1:0] w_deb;
   logic                w_commit;

   sw_state_e           r_state;
   sw_state_e           w_state_nxt;
   logic [SW_WIDTH-1:0] r_data;
   logic [SW_WIDTH-1:0] w_data_nxt;
   logic                r_valid;
   logic                w_valid_nxt;
   logic                r_pend;
   logic                w_pend_nxt;
   logic                r_ovr;
   logic                w_ovr_nxt;

   sw_sync_debounce #(
      .SW_WIDTH     (SW_WIDTH),
      .TICK_DIV     (TICK_DIV),
      .STABLE_TICKS (STABLE_TICKS)
   ) u_deb (
      .i_clk    (clk_i),
      .i_rst    (rst_i),
      .i_sw     (SW_i),
      .o_deb    (w_deb),
      .o_commit (w_commit)
   );

   assign sw_level_o   = w_deb;
   assign sw_data_o    = r_data;
   assign sw_valid_o   = r_valid;
   assign sw_overrun_o = r_ovr;

   always_comb begin
      w_state_nxt = r_state;
      w_data_nxt  = r_data;
      w_valid_nxt = r_valid;
      w_pend_nxt  = r_pend;
      w_ovr_nxt   = r_ovr;
      unique case (r_state)
         ST_IDLE: begin
            if (w_commit || r_pend) begin
               w_data_nxt  = w_deb;
               w_valid_nxt = 1'b1;
               w_pend_nxt  = 1'b0;
               w_state_nxt = ST_VALID;
            end
         end
         ST_VALID: begin
            if (sw_ack_i) begin
               w_valid_nxt = 1'b0;
               w_state_nxt = ST_IDLE;
            end
            // Data stays frozen; only the newest level is offered later.
            if (w_commit) begin
               w_pend_nxt = 1'b1;
               w_ovr_nxt  = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_pend  <= 1'b0;
         r_ovr   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_data  <= w_data_nxt;
         r_valid <= w_valid_nxt;
         r_pend  <= w_pend_nxt;
         r_ovr   <= w_ovr_nxt;
      end
   end

endmodule
